// File: rtl/jtag_drv_pkg.sv
// Shared encodings for the JTAG initiator: command types, FSM states and the
// fixed TMS walks that enter and leave the shift states from Run-Test/Idle.
package jtag_drv_pkg;

    localparam int LEN_W = 6;

    localparam logic [1:0] CMD_TMS_SEQ   = 2'd0;
    localparam logic [1:0] CMD_SHIFT_IR  = 2'd1;
    localparam logic [1:0] CMD_SHIFT_DR  = 2'd2;
    localparam logic [1:0] CMD_TAP_RESET = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SHIFT,
        ST_POST,
        ST_RESP
    } state_t;

    // TMS walks, bit 0 is driven first; *_LAST is the index of the final bit.
    localparam logic [4:0] PRE_IR          = 5'b00011;
    localparam logic [4:0] PRE_DR          = 5'b00001;
    localparam logic [4:0] PRE_RST         = 5'b11111;
    localparam logic [4:0] POST_SHIFT      = 5'b00001;
    localparam logic [4:0] POST_RST        = 5'b00000;
    localparam logic [2:0] PRE_IR_LAST     = 3'd3;
    localparam logic [2:0] PRE_DR_LAST     = 3'd2;
    localparam logic [2:0] PRE_RST_LAST    = 3'd4;
    localparam logic [2:0] POST_SHIFT_LAST = 3'd1;
    localparam logic [2:0] POST_RST_LAST   = 3'd0;

    function automatic logic [4:0] pre_pat(input logic [1:0] t);
        case (t)
            CMD_SHIFT_IR:  return PRE_IR;
            CMD_SHIFT_DR:  return PRE_DR;
            CMD_TAP_RESET: return PRE_RST;
            default:       return 5'b00000;
        endcase
    endfunction

    function automatic logic [2:0] pre_last(input logic [1:0] t);
        case (t)
            CMD_SHIFT_IR:  return PRE_IR_LAST;
            CMD_SHIFT_DR:  return PRE_DR_LAST;
            CMD_TAP_RESET: return PRE_RST_LAST;
            default:       return 3'd0;
        endcase
    endfunction

    function automatic logic [4:0] post_pat(input logic [1:0] t);
        return (t == CMD_TAP_RESET) ? POST_RST : POST_SHIFT;
    endfunction

    function automatic logic [2:0] post_last(input logic [1:0] t);
        return (t == CMD_TAP_RESET) ? POST_RST_LAST : POST_SHIFT_LAST;
    endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK generator: low phase then high phase of CLK_DIV clocks each, with
// strobes marking the clk edge that drives TCK low (period start) or high.
module jtag_tck_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tck,
    output logic fall_stb,
    output logic rise_stb
);

    localparam int CNT_W = $clog2(2 * CLK_DIV);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(2 * CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign fall_stb = en && (cnt == '0);
    assign rise_stb = en && (cnt == HALF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            tck <= 1'b0;
        end else if (!en) begin
            cnt <= '0;
            tck <= 1'b0;
        end else begin
            cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
            if (rise_stb)
                tck <= 1'b1;
            else if (fall_stb)
                tck <= 1'b0;
        end
    end

endmodule

// File: rtl/jtag_drv.sv
// JTAG initiator: runs one TMS/IR/DR/reset command at a time from RTI back to
// RTI and returns the TDO bits captured during the shift through a response.
module jtag_drv
    import jtag_drv_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int MAX_LEN = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_type,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               busy,
    output logic               jtag_tck,
    output logic               jtag_tms,
    output logic               jtag_tdi,
    input  logic               jtag_tdo
);

    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    state_t             state;
    logic [1:0]         type_r;
    logic [LEN_W-1:0]   last_idx;
    logic [LEN_W-1:0]   eff_last;
    logic [LEN_W-1:0]   idx;
    logic [MAX_LEN-1:0] data_r;
    logic               last;
    logic               cap_en;
    logic [IDX_W-1:0]   cap_idx;
    logic               tck_en;
    logic               fall_stb;
    logic               rise_stb;
    logic [4:0]         pre_bits;
    logic [4:0]         post_bits;
    logic [2:0]         pre_end;
    logic [2:0]         post_end;
    logic               shift_bit;
    logic               shift_end;

    assign tck_en    = (state == ST_PRE) || (state == ST_SHIFT) || (state == ST_POST);
    assign pre_bits  = pre_pat(type_r);
    assign pre_end   = pre_last(type_r);
    assign post_bits = post_pat(type_r);
    assign post_end  = post_last(type_r);
    assign shift_bit = data_r[idx[IDX_W-1:0]];
    assign shift_end = (idx == last_idx);

    // Length 0 behaves as a single bit; anything beyond MAX_LEN saturates.
    always_comb begin
        eff_last = '0;
        if (cmd_len == '0)
            eff_last = '0;
        else if (cmd_len > LEN_W'(MAX_LEN))
            eff_last = LEN_W'(MAX_LEN - 1);
        else
            eff_last = cmd_len - LEN_W'(1);
    end

    jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (tck_en),
        .tck      (jtag_tck),
        .fall_stb (fall_stb),
        .rise_stb (rise_stb)
    );

    // Valid/ready: a transfer happens on any clk edge where valid and ready are
    // both high; rsp_valid/rsp_data hold until that edge, cmd is taken only in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            jtag_tms  <= 1'b1;
            jtag_tdi  <= 1'b0;
            type_r    <= CMD_TMS_SEQ;
            last_idx  <= '0;
            data_r    <= '0;
            idx       <= '0;
            last      <= 1'b0;
            cap_en    <= 1'b0;
            cap_idx   <= '0;
        end else begin
            if (rise_stb && cap_en)
                rsp_data[cap_idx] <= jtag_tdo;
            case (state)
                ST_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        type_r    <= cmd_type;
                        last_idx  <= eff_last;
                        data_r    <= cmd_data;
                        idx       <= '0;
                        last      <= 1'b0;
                        state     <= (cmd_type == CMD_TMS_SEQ) ? ST_SHIFT : ST_PRE;
                    end
                end
                ST_PRE, ST_SHIFT, ST_POST: begin
                    // Each period start drives the next bit; 'last' marks the final period.
                    if (fall_stb) begin
                        cap_en   <= 1'b0;
                        jtag_tdi <= 1'b0;
                        if (last) begin
                            jtag_tms  <= 1'b0;
                            last      <= 1'b0;
                            rsp_valid <= 1'b1;
                            state     <= ST_RESP;
                        end else if (state == ST_PRE) begin
                            jtag_tms <= pre_bits[idx[2:0]];
                            if (idx[2:0] == pre_end) begin
                                idx   <= '0;
                                state <= (type_r == CMD_TAP_RESET) ? ST_POST : ST_SHIFT;
                            end else begin
                                idx <= idx + LEN_W'(1);
                            end
                        end else if (state == ST_SHIFT) begin
                            jtag_tms <= (type_r == CMD_TMS_SEQ) ? shift_bit : shift_end;
                            jtag_tdi <= (type_r == CMD_TMS_SEQ) ? 1'b0 : shift_bit;
                            cap_en   <= 1'b1;
                            cap_idx  <= idx[IDX_W-1:0];
                            if (shift_end) begin
                                idx <= '0;
                                if (type_r == CMD_TMS_SEQ)
                                    last <= 1'b1;
                                else
                                    state <= ST_POST;
                            end else begin
                                idx <= idx + LEN_W'(1);
                            end
                        end else begin
                            jtag_tms <= post_bits[idx[2:0]];
                            if (idx[2:0] == post_end)
                                last <= 1'b1;
                            else
                                idx <= idx + LEN_W'(1);
                        end
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_data  <= '0;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/jtag_drv.md
Name: jtag_drv

Overview:
- Synthesizable JTAG initiator. Drives TCK/TMS/TDI into the chip's JTAG input pads and samples TDO from the chip's TDO pad.
- Used by on-board bring-up logic and by the pad-level testbench to reach the e203 debug module.
- Executes one command at a time: reset, raw TMS sequence, IR shift or DR shift. Returns captured TDO bits through a valid/ready response channel.
- The TAP is parked in Run-Test/Idle (RTI) between commands.

Parameters:
- CLK_DIV, 4: clk cycles per TCK half-period (legal range >= 1).
- MAX_LEN, 32: maximum shift length in bits; sets the width of cmd_data and rsp_data.

Ports:
- clk  in  1  system clock (single clock domain).
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_type  in  2  0=TMS_SEQ, 1=SHIFT_IR, 2=SHIFT_DR, 3=TAP_RESET.
- cmd_len  in  6  bit count for TMS_SEQ/SHIFT_*.
- cmd_data  in  MAX_LEN  TMS bits (TMS_SEQ) or TDI bits (SHIFT_*), LSB first.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response accepted.
- rsp_data  out  MAX_LEN  captured TDO, LSB = first shifted bit.
- busy  out  1  high whenever the state is not IDLE.
- jtag_tck  out  1  to the TCK pad.
- jtag_tms  out  1  to the TMS pad.
- jtag_tdi  out  1  to the TDI pad.
- jtag_tdo  in  1  from the TDO pad (already resolved by the pad; no OE).

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: jtag_tck=0, jtag_tms=1, jtag_tdi=0, cmd_ready=0 during reset and 1 in the first cycle after release, rsp_valid=0, rsp_data=0, busy=0. State = IDLE.
- Bit period: each TAP bit is one TCK period = 2*CLK_DIV clk cycles.
  - Low phase first, then high phase.
  - TMS/TDI update on the clk edge that drives TCK low (the period start).
  - TDO is sampled on the clk edge that drives TCK high.
  - TCK always returns low at command end.
- Handshake:
  - A command is accepted when cmd_valid && cmd_ready. cmd_type, cmd_len and cmd_data are registered on acceptance.
  - Effective length L = clamp(cmd_len, 1, MAX_LEN), so 0 becomes 1 and values above 32 become 32.
- FSM states: IDLE -> PRE -> SHIFT -> POST -> RESP -> IDLE.
  - TMS_SEQ: skips PRE and POST. SHIFT emits L bits with TMS=cmd_data[i], TDI=0. TDO is captured anyway.
  - SHIFT_IR: PRE TMS=1,1,0,0. SHIFT emits L bits, TDI=cmd_data[i], TMS=0 except TMS=1 on the last bit. POST TMS=1,0. Total L+6 periods.
  - SHIFT_DR: PRE TMS=1,0,0. SHIFT as for IR. POST TMS=1,0. Total L+5 periods.
  - TAP_RESET: PRE TMS=1,1,1,1,1 and POST TMS=0, with no SHIFT. Total 6 periods. rsp_data=0.
- Capture: rsp_data bit i = TDO sampled during SHIFT bit i. Bits at index L and above are 0.
- Response:
  - rsp_valid rises 1 clk after the final period's high phase ends.
  - rsp_valid and rsp_data are held stable until rsp_ready. They are cleared on the cycle rsp_valid && rsp_ready, and the state returns to IDLE.
  - cmd_ready is 0 from acceptance until the response handshake completes. There is no command overlap.
- Latency: acceptance -> rsp_valid = 1 + P*2*CLK_DIV clk cycles, where P is the period count.
- Idle outputs: TMS=0, TDI=0, TCK=0, except after reset, where TMS stays 1 until the first command.
- Reset mid-operation: the state is abandoned immediately and outputs take their reset values. No response is produced. Software must issue TAP_RESET.
- cmd_valid asserted while busy is ignored. It is not queued.

Decomposition:
- jtag_drv_pkg holds:
  - the cmd_type encodings (CMD_TMS_SEQ..CMD_TAP_RESET);
  - the FSM state enum;
  - the PRE/POST TMS pattern constants and their lengths;
  - the LEN_W localparam.
- One sub-module, jtag_tck_gen: half-period counter that drives TCK and emits fall_stb/rise_stb one-cycle strobes. It is enabled by the FSM and resets to TCK=0.

Test Plan:
- CLK_DIV=2, TAP_RESET -> 6 TCK pulses, TMS per period 1,1,1,1,1,0; rsp_valid exactly 25 clks after accept; rsp_data=0.
- TAP_RESET then SHIFT_DR L=32, data=0, against a bench TAP model with IDCODE 0x1E200A6D -> rsp_data=0x1E200A6D; 37 TCK periods.
- SHIFT_IR L=5, data=5'h01 -> model IR=0x01; rsp_data=0x00000001 (capture pattern xx01); TMS=1 on 5th shift bit; ends in RTI.
- TMS_SEQ L=3, data=3'b011 -> TMS sequence 1,1,0; TDI=0 throughout; cmd_len=0 variant -> exactly 1 TCK period; cmd_len=40 -> 32 periods.
- Hold rsp_ready=0 for 10 clks after rsp_valid -> rsp_valid/rsp_data stable, cmd_ready=0, a second cmd_valid is ignored; the command is accepted after the handshake.
- Assert rst_n=0 mid-SHIFT_DR at bit 10 -> same cycle TCK=0, TMS=1, TDI=0; no rsp_valid; after release cmd_ready=1 and a TAP_RESET + IDCODE read passes.
